fwd_hazard_unit: RTL and testbench

Parametrised forwarding and load-use interlock unit for the mips789 integer pipeline. It tracks the destination register of every in-flight instruction through an internal NSTAGE-deep shadow pipeline. It generates forward-select codes for both consumer points: the ID-stage comparator and the EX-stage ALU/store-data path. It also raises a load-use stall, so the surrounding datapath no longer supplies per-stage destination numbers.

---
 rtl/fwd_hazard_unit.sv | 166 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use interlock unit for the mips789 integer pipeline.
// Define FWD_LOAD_STALL_EN to enable the load-use interlock; otherwise loads forward like ALU results.
module fwd_hazard_unit #(
    parameter  int RN_W   = 5,
    parameter  int NPORT  = 2,
    parameter  int NSTAGE = 3,
    localparam int SEL_W  = $clog2(NSTAGE + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    pause,
    input  logic                    flush,
    input  logic [NPORT*RN_W-1:0]   id_rn,
    input  logic [NPORT-1:0]        id_use,
    input  logic [RN_W-1:0]         id_wr_rn,
    input  logic                    id_we,
    input  logic                    id_ld,
    output logic [NPORT*SEL_W-1:0]  id_fw,
    output logic [NPORT*SEL_W-1:0]  ex_fw,
    output logic                    stall
);

    logic [RN_W-1:0]        rn_q [1:NSTAGE];
    logic [RN_W-1:0]        rn_d [1:NSTAGE];
    logic [NSTAGE:1]        we_q;
    logic [NSTAGE:1]        we_d;
    logic [NPORT*RN_W-1:0]  ex_rn_q;
    logic [NPORT*RN_W-1:0]  ex_rn_d;
    logic [NPORT-1:0]       ex_use_q;
    logic [NPORT-1:0]       ex_use_d;
    logic                   ld1_s;
    logic                   hazard_s;

`ifdef FWD_LOAD_STALL_EN
    logic [NSTAGE:1]        ld_q;
    logic [NSTAGE:1]        ld_d;
    assign ld1_s = ld_q[1];
`else
    logic                   unused_ld_s;
    assign unused_ld_s = id_ld;
    assign ld1_s       = 1'b0;
`endif

    // A stage only produces a forwardable result if it writes a non-zero register.
    function automatic logic prod_valid(input logic we, input logic [RN_W-1:0] rn);
        return we && (rn != {RN_W{1'b0}});
    endfunction

    // Load-use hazard: the instruction in stage 1 is a load whose target ID reads.
    always_comb begin
        hazard_s = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (id_use[p] && ld1_s && prod_valid(we_q[1], rn_q[1]) &&
                (rn_q[1] == id_rn[p*RN_W +: RN_W])) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    assign stall = hazard_s;

    // ID-stage selects: scan oldest to youngest so the youngest match overrides.
    always_comb begin
        id_fw = {(NPORT*SEL_W){1'b0}};
        for (int p = 0; p < NPORT; p++) begin
            logic [SEL_W-1:0] sel_s;
            sel_s = {SEL_W{1'b0}};
            for (int k = NSTAGE; k >= 32'sd1; k--) begin
                if (id_use[p] && prod_valid(we_q[k], rn_q[k]) &&
                    (rn_q[k] == id_rn[p*RN_W +: RN_W])) begin
                    if ((k == 32'sd1) && ld1_s) begin
                        sel_s = {SEL_W{1'b0}};
                    end else begin
                        sel_s = SEL_W'(k);
                    end
                end else begin
                    sel_s = sel_s;
                end
            end
            id_fw[p*SEL_W +: SEL_W] = sel_s;
        end
    end

    // EX-stage selects: the consumer is the instruction in stage 1, producers are older.
    always_comb begin
        ex_fw = {(NPORT*SEL_W){1'b0}};
        for (int p = 0; p < NPORT; p++) begin
            logic [SEL_W-1:0] sel_s;
            sel_s = {SEL_W{1'b0}};
            for (int k = NSTAGE; k >= 32'sd2; k--) begin
                if (ex_use_q[p] && prod_valid(we_q[k], rn_q[k]) &&
                    (rn_q[k] == ex_rn_q[p*RN_W +: RN_W])) begin
                    sel_s = SEL_W'(k);
                end else begin
                    sel_s = sel_s;
                end
            end
            ex_fw[p*SEL_W +: SEL_W] = sel_s;
        end
    end

    // Shadow pipeline next state: hold on pause, otherwise shift and fill stage 1.
    always_comb begin
        rn_d     = rn_q;
        we_d     = we_q;
        ex_rn_d  = ex_rn_q;
        ex_use_d = ex_use_q;
`ifdef FWD_LOAD_STALL_EN
        ld_d     = ld_q;
`endif
        if (pause) begin
            rn_d = rn_q;
        end else begin
            for (int k = NSTAGE; k >= 32'sd2; k--) begin
                rn_d[k] = rn_q[k-1];
                we_d[k] = we_q[k-1];
`ifdef FWD_LOAD_STALL_EN
                ld_d[k] = ld_q[k-1];
`endif
            end
            if (flush || hazard_s) begin
                rn_d[1]  = {RN_W{1'b0}};
                we_d[1]  = 1'b0;
                ex_rn_d  = {(NPORT*RN_W){1'b0}};
                ex_use_d = {NPORT{1'b0}};
`ifdef FWD_LOAD_STALL_EN
                ld_d[1]  = 1'b0;
`endif
            end else begin
                rn_d[1]  = id_wr_rn;
                we_d[1]  = id_we;
                ex_rn_d  = id_rn;
                ex_use_d = id_use;
`ifdef FWD_LOAD_STALL_EN
                ld_d[1]  = id_ld;
`endif
            end
        end
    end

    // Shadow pipeline registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                rn_q[k] <= {RN_W{1'b0}};
            end
            we_q     <= {NSTAGE{1'b0}};
            ex_rn_q  <= {(NPORT*RN_W){1'b0}};
            ex_use_q <= {NPORT{1'b0}};
`ifdef FWD_LOAD_STALL_EN
            ld_q     <= {NSTAGE{1'b0}};
`endif
        end else begin
            rn_q     <= rn_d;
            we_q     <= we_d;
            ex_rn_q  <= ex_rn_d;
            ex_use_q <= ex_use_d;
`ifdef FWD_LOAD_STALL_EN
            ld_q     <= ld_d;
`endif
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus random traffic
// checked against an in-flight instruction list model.
module tb_fwd_hazard_unit;

`ifdef FWD_LOAD_STALL_EN
    localparam bit LDEN = 1'b1;
`else
    localparam bit LDEN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pause = 1'b0;
    logic       flush = 1'b0;
    logic [9:0] id_rn = 10'd0;
    logic [1:0] id_use = 2'd0;
    logic [4:0] id_wr_rn = 5'd0;
    logic       id_we = 1'b0;
    logic       id_ld = 1'b0;
    logic [3:0] id_fw;
    logic [3:0] ex_fw;
    logic       stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.RN_W(5), .NPORT(2), .NSTAGE(3)) dut (
        .clk(clk), .rst(rst), .pause(pause), .flush(flush),
        .id_rn(id_rn), .id_use(id_use), .id_wr_rn(id_wr_rn),
        .id_we(id_we), .id_ld(id_ld),
        .id_fw(id_fw), .ex_fw(ex_fw), .stall(stall)
    );

    // Instructions in flight; pipe[k] is the instruction whose result is at stage k.
    typedef struct packed {
        logic [4:0] rn;
        logic       we;
        logic       ld;
        logic [9:0] src;
        logic [1:0] srcuse;
    } instr_t;
    instr_t pipe [1:3];

    function automatic bit writes(int k, logic [4:0] r);
        return pipe[k].we && pipe[k].rn != 5'd0 && pipe[k].rn == r;
    endfunction

    function automatic int exp_id(int p);
        if (!id_use[p]) return 0;
        for (int k = 1; k <= 3; k++)
            if (writes(k, id_rn[p*5 +: 5]))
                return (k == 1 && LDEN && pipe[1].ld) ? 0 : k;
        return 0;
    endfunction

    function automatic int exp_ex(int p);
        if (!pipe[1].srcuse[p]) return 0;
        for (int k = 2; k <= 3; k++)
            if (writes(k, pipe[1].src[p*5 +: 5])) return k;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit s = 1'b0;
        for (int p = 0; p < 2; p++)
            if (LDEN && pipe[1].ld && id_use[p] && writes(1, id_rn[p*5 +: 5])) s = 1'b1;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic drv(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] u,
                       input logic [4:0] wr, input logic we, input logic ld,
                       input logic pz, input logic fl);
        id_rn = {rt, rs}; id_use = u; id_wr_rn = wr; id_we = we; id_ld = ld;
        pause = pz; flush = fl;
    endtask

    task automatic idle();
        drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Check model (and optional directed values) at negedge, then advance model at posedge.
    task automatic cyc(input bit d, input logic [3:0] i0, input logic [3:0] i1,
                       input logic [3:0] e0, input logic [3:0] e1, input logic st);
        bit s;
        @(negedge clk);
        chk("m_id_fw0", {2'b00, id_fw[1:0]}, 4'(exp_id(0)));
        chk("m_id_fw1", {2'b00, id_fw[3:2]}, 4'(exp_id(1)));
        chk("m_ex_fw0", {2'b00, ex_fw[1:0]}, 4'(exp_ex(0)));
        chk("m_ex_fw1", {2'b00, ex_fw[3:2]}, 4'(exp_ex(1)));
        chk("m_stall", {3'b000, stall}, {3'b000, exp_stall()});
        if (d) begin
            chk("d_id_fw0", {2'b00, id_fw[1:0]}, i0);
            chk("d_id_fw1", {2'b00, id_fw[3:2]}, i1);
            chk("d_ex_fw0", {2'b00, ex_fw[1:0]}, e0);
            chk("d_ex_fw1", {2'b00, ex_fw[3:2]}, e1);
            chk("d_stall", {3'b000, stall}, {3'b000, st});
        end
        @(posedge clk);
        if (rst && !pause) begin
            s = exp_stall();
            pipe[3] = pipe[2];
            pipe[2] = pipe[1];
            if (flush || s) pipe[1] = '0;
            else pipe[1] = '{rn: id_wr_rn, we: id_we, ld: id_ld, src: id_rn, srcuse: id_use};
        end
        #1;
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 3; i++) cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    initial begin
        for (int k = 1; k <= 3; k++) pipe[k] = '0;
        idle();
        #2;
        chk("rst_id_fw", id_fw, 4'd0);
        chk("rst_ex_fw", ex_fw, 4'd0);
        chk("rst_stall", {3'b000, stall}, 4'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Back-to-back ALU producer r5 with dependents one, two and three behind.
        drv(5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd2, 4'd0, 4'd2, 4'd0, 1'b0);
        idle();                                              cyc(1'b1, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0);
        drain();

        // Youngest producer wins; r0 never forwards.
        drv(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd0, 5'd7, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
        drv(5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd2, 1'b0);
        drv(5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drain();

        // Load r9 followed by a reader of r9 on rs, ID held for a second cycle.
        drv(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (LDEN) begin
            cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
            cyc(1'b1, 4'd2, 4'd0, 4'd0, 4'd0, 1'b0);
        end else begin
            cyc(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
            cyc(1'b1, 4'd2, 4'd0, 4'd2, 4'd0, 1'b0);
        end
        drain();
        drv(5'd0, 5'd0, 2'b00, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd9, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drain();

        // Pause holds r4 in stage 1; flush squashes a later r4 writer.
        drv(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        drain();
        drv(5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd4, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drain();

        // Asynchronous reset mid-run clears everything before the next edge.
        drv(5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0); cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        drv(5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd1, 4'd0, 4'd0, 4'd0, 1'b0);
        idle();
        rst = 1'b0;
        #1;
        chk("arst_id_fw", id_fw, 4'd0);
        chk("arst_ex_fw", ex_fw, 4'd0);
        chk("arst_stall", {3'b000, stall}, 4'd0);
        for (int k = 1; k <= 3; k++) pipe[k] = '0;
        @(posedge clk); #1;
        rst = 1'b1;
        drv(5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); cyc(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);

        // Random traffic over a small register window to provoke frequent matches.
        for (int i = 0; i < 400; i++) begin
            drv(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 7) == 0));
            cyc(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
